// File: rtl/segment_scheduler_pkg.sv
// Shared state encodings and default widths for the segment scheduler.
package segment_scheduler_pkg;

    localparam int DUR_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWAP  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

endpackage

// File: rtl/segment_scheduler_valid_delay_line.sv
// Sample-valid delay line: aligns the FIFO write strobe with the oscillator
// pipeline. A sample entering in cycle k leaves in cycle k+STAGES.
module valid_delay_line #(
    parameter int STAGES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [STAGES:1] vld_pipe;

    // Shift toward the output; flush empties every stage including the new input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= din;
            for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign dout = vld_pipe[STAGES];

endmodule

// File: rtl/segment_scheduler.sv
// Segment playback sequencer for the oscillator bank: swaps the shadow bank
// into the active bank, counts segment samples, stalls on FIFO full and
// drives the pipeline-aligned FIFO write strobe.
module segment_scheduler
    import segment_scheduler_pkg::*;
#(
    parameter int DUR_W    = DUR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             load_done,
    input  logic [DUR_W-1:0] duration_in,
    input  logic             loop_mode,
    input  logic             fifo_full,
    output logic             swap,
    output logic             sample_en,
    output logic             fifo_wr_en,
    output logic             seg_done,
    output logic             finished,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] seg_count
);

    localparam int DW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);

    sched_state_t     state, state_d;
    logic             shadow_valid, shadow_valid_d;
    logic [DUR_W-1:0] pending_dur, pending_dur_d;
    logic [DUR_W-1:0] remaining, remaining_d;
    logic [DUR_W-1:0] active_dur, active_dur_d;
    logic [CNT_W-1:0] seg_count_d;
    logic [DW-1:0]    drain_cnt, drain_cnt_d;
    logic             seg_done_d, finished_d, flush;

    assign swap      = (state == SWAP);
    assign sample_en = (state == RUN) && !fifo_full;
    assign busy      = (state != IDLE);
    assign state_o   = state;

    // State and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shadow_valid <= 1'b0;
            pending_dur  <= '0;
            remaining    <= '0;
            active_dur   <= '0;
            seg_count    <= '0;
            drain_cnt    <= '0;
            seg_done     <= 1'b0;
            finished     <= 1'b0;
        end else begin
            state        <= state_d;
            shadow_valid <= shadow_valid_d;
            pending_dur  <= pending_dur_d;
            remaining    <= remaining_d;
            active_dur   <= active_dur_d;
            seg_count    <= seg_count_d;
            drain_cnt    <= drain_cnt_d;
            seg_done     <= seg_done_d;
            finished     <= finished_d;
        end
    end

    // Next-state logic, segment end rule, load capture and abort override.
    always_comb begin
        state_d        = state;
        shadow_valid_d = shadow_valid;
        pending_dur_d  = pending_dur;
        remaining_d    = remaining;
        active_dur_d   = active_dur;
        seg_count_d    = seg_count;
        drain_cnt_d    = drain_cnt;
        seg_done_d     = 1'b0;
        finished_d     = 1'b0;
        flush          = 1'b0;

        case (state)
            IDLE: begin
                if (start && shadow_valid) begin
                    seg_count_d = '0;
                    state_d     = SWAP;
                end
            end
            SWAP: begin
                shadow_valid_d = 1'b0;
                remaining_d    = pending_dur;
                active_dur_d   = pending_dur;
                seg_count_d    = seg_count + CNT_W'(1);
                if (pending_dur == '0) begin
                    // Empty segment ends at once. Only a load arriving now can
                    // chain; looping an empty segment would spin without samples.
                    seg_done_d = 1'b1;
                    if (load_done) begin
                        state_d = SWAP;
                    end else begin
                        state_d     = DRAIN;
                        drain_cnt_d = DW'(PIPE_LAT - 1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sample_en) begin
                    remaining_d = remaining - DUR_W'(1);
                    if (remaining == DUR_W'(1)) begin
                        seg_done_d = 1'b1;
                        if (shadow_valid) begin
                            state_d = SWAP;
                        end else if (loop_mode) begin
                            remaining_d = active_dur;
                            seg_count_d = seg_count + CNT_W'(1);
                        end else begin
                            state_d     = DRAIN;
                            drain_cnt_d = DW'(PIPE_LAT - 1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d    = IDLE;
                    finished_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A new load always wins, including over the SWAP consumption above.
        if (load_done) begin
            shadow_valid_d = 1'b1;
            pending_dur_d  = duration_in;
        end

        // Abort stops everything but keeps the shadow bank and segment count.
        if (abort) begin
            state_d        = IDLE;
            seg_done_d     = 1'b0;
            finished_d     = 1'b0;
            flush          = 1'b1;
            seg_count_d    = seg_count;
            shadow_valid_d = shadow_valid | load_done;
        end
    end

    valid_delay_line #(.STAGES(PIPE_LAT)) u_vdl (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .din   (sample_en),
        .dout  (fifo_wr_en)
    );

endmodule
